// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 8-bit lab CPU: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB/DONE and drives registered datapath controls.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [7:0]           instruction,
  input  logic                 mem_ready,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 branch,
  output logic                 memtoreg,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 aluop,
  output logic                 alusrc,
  output logic                 regwrite,
  output logic                 regdst,
  output logic [2:0]           state_out,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic                   step_prev_q;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;
  logic                   err_q, err_d;
  // {ir_load, pc_write, pc_src, branch, memtoreg, memread, memwrite, aluop, alusrc, regwrite, regdst}
  logic [10:0]            ctrl_q, ctrl_d;
  logic                   step_rise_s;
  logic                   unused_instr_s;

  assign step_rise_s    = step & ~step_prev_q;
  assign unused_instr_s = ^instruction[5:0];

  // Next-state, op latch, MEM timeout, retire counter and sticky error.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_IDLE: begin
        if (run || step_rise_s) state_d = S_FETCH;
        else                    state_d = S_IDLE;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instruction[7:6];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = {TW{1'b0}};
        case (op_q)
          OP_ADD:       state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_J:         state_d = S_DONE;
          default:      state_d = S_DONE;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WB: state_d = S_DONE;
      S_DONE: begin
        instr_count_d = instr_count_q + CNT_WIDTH'(1);
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    err_d = err_q | (state_d == S_ERROR);
  end

  // Control lines decoded one cycle early from the next state so they leave a flop.
  always_comb begin
    ctrl_d = 11'd0;
    case (state_d)
      S_FETCH: ctrl_d[10] = 1'b1;
      S_EXEC: begin
        case (op_d)
          OP_ADD:       ctrl_d[3] = 1'b1;
          OP_LW, OP_SW: ctrl_d[2] = 1'b1;
          OP_J:         ctrl_d[8:7] = 2'b11;
          default:      ctrl_d = 11'd0;
        endcase
      end
      S_MEM: begin
        case (op_d)
          OP_LW:   ctrl_d[5] = 1'b1;
          OP_SW:   ctrl_d[4] = 1'b1;
          default: ctrl_d = 11'd0;
        endcase
        ctrl_d[2] = (op_d == OP_LW) || (op_d == OP_SW);
      end
      S_WB: begin
        case (op_d)
          OP_ADD:  ctrl_d[1:0] = 2'b11;
          OP_LW: begin
            ctrl_d[6] = 1'b1;
            ctrl_d[1] = 1'b1;
          end
          default: ctrl_d = 11'd0;
        endcase
      end
      S_DONE: begin
        ctrl_d[9] = 1'b1;
        if (op_d == OP_J) ctrl_d[8:7] = 2'b11;
        else              ctrl_d[8:7] = 2'b00;
      end
      default: ctrl_d = 11'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      step_prev_q   <= 1'b0;
      cnt_q         <= {TW{1'b0}};
      instr_count_q <= {CNT_WIDTH{1'b0}};
      err_q         <= 1'b0;
      ctrl_q        <= 11'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      step_prev_q   <= step;
      cnt_q         <= cnt_d;
      instr_count_q <= instr_count_d;
      err_q         <= err_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign {ir_load, pc_write, pc_src, branch, memtoreg, memread,
          memwrite, aluop, alusrc, regwrite, regdst} = ctrl_q;
  assign state_out   = state_q;
  assign instr_count = instr_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer plus hand-written
// sequences for timeout, async reset, single-step and late instruction changes.
module tb_multicycle_sequencer;

  localparam logic [10:0] C_IR  = 11'h400;
  localparam logic [10:0] C_PCW = 11'h200;
  localparam logic [10:0] C_PCS = 11'h100;
  localparam logic [10:0] C_BR  = 11'h080;
  localparam logic [10:0] C_M2R = 11'h040;
  localparam logic [10:0] C_MR  = 11'h020;
  localparam logic [10:0] C_MW  = 11'h010;
  localparam logic [10:0] C_AOP = 11'h008;
  localparam logic [10:0] C_ASR = 11'h004;
  localparam logic [10:0] C_RW  = 11'h002;
  localparam logic [10:0] C_RD  = 11'h001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  instruction = 8'h00;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_write, pc_src, branch, memtoreg, memread;
  logic        memwrite, aluop, alusrc, regwrite, regdst, err;
  logic [2:0]  state_out;
  logic [15:0] instr_count;
  logic [10:0] ctrl;

  int checks = 0;
  int failures = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instruction(instruction), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
    .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
    .aluop(aluop), .alusrc(alusrc), .regwrite(regwrite), .regdst(regdst),
    .state_out(state_out), .instr_count(instr_count), .err(err)
  );

  assign ctrl = {ir_load, pc_write, pc_src, branch, memtoreg, memread,
                 memwrite, aluop, alusrc, regwrite, regdst};

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        step;
    logic [7:0]  instr;
    logic        mrdy;
    logic [2:0]  st;
    logic [10:0] ctrl;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic [7:0] ins,
                     input logic m, input logic [2:0] st, input logic [10:0] c,
                     input logic [15:0] n);
    vec_t v;
    v.run = r; v.step = s; v.instr = ins; v.mrdy = m;
    v.st = st; v.ctrl = c; v.cnt = n;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; step = 1'b0; mem_ready = 1'b0; instruction = 8'h00;
    tick();
    tick();
    check("reset_state", {29'd0, state_out}, 32'd0);
    check("reset_ctrl", {21'd0, ctrl}, 32'd0);
    check("reset_count", {16'd0, instr_count}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin : main
    int  mw_cycles;
    bit  hit;
    bit  saw_mw, saw_wb;

    // ADD x2, LW with a ready ignored in EXEC and a 3-cycle wait, J with run
    // dropped mid-instruction, then a zero-wait SW in run mode.
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd1, C_IR, 16'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 11'd0, 16'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd3, C_AOP, 16'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd5, C_RW | C_RD, 16'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd6, C_PCW, 16'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd1, C_IR, 16'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 11'd0, 16'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd3, C_AOP, 16'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd5, C_RW | C_RD, 16'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd6, C_PCW, 16'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 3'd1, C_IR, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd2, 11'd0, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd3, C_ASR, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b1, 3'd4, C_ASR | C_MR, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd4, C_ASR | C_MR, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd4, C_ASR | C_MR, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b1, 3'd5, C_RW | C_M2R, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd6, C_PCW, 16'd2);
    add(1'b1, 1'b0, 8'h40, 1'b0, 3'd1, C_IR, 16'd3);
    add(1'b1, 1'b0, 8'hC0, 1'b0, 3'd2, 11'd0, 16'd3);
    add(1'b1, 1'b0, 8'hC0, 1'b0, 3'd3, C_PCS | C_BR, 16'd3);
    add(1'b0, 1'b0, 8'hC0, 1'b0, 3'd6, C_PCW | C_PCS | C_BR, 16'd3);
    add(1'b0, 1'b0, 8'hC0, 1'b0, 3'd0, 11'd0, 16'd4);
    add(1'b0, 1'b0, 8'hC0, 1'b0, 3'd0, 11'd0, 16'd4);
    add(1'b1, 1'b0, 8'h80, 1'b0, 3'd1, C_IR, 16'd4);
    add(1'b1, 1'b0, 8'h80, 1'b0, 3'd2, 11'd0, 16'd4);
    add(1'b1, 1'b0, 8'h80, 1'b0, 3'd3, C_ASR, 16'd4);
    add(1'b1, 1'b0, 8'h80, 1'b0, 3'd4, C_ASR | C_MW, 16'd4);
    add(1'b1, 1'b0, 8'h80, 1'b1, 3'd6, C_PCW, 16'd4);
    add(1'b0, 1'b0, 8'h80, 1'b0, 3'd0, 11'd0, 16'd5);

    do_reset();
    foreach (tbl[i]) begin
      run = tbl[i].run; step = tbl[i].step;
      instruction = tbl[i].instr; mem_ready = tbl[i].mrdy;
      tick();
      check($sformatf("vec%0d_state", i), {29'd0, state_out}, {29'd0, tbl[i].st});
      check($sformatf("vec%0d_ctrl", i), {21'd0, ctrl}, {21'd0, tbl[i].ctrl});
      check($sformatf("vec%0d_count", i), {16'd0, instr_count}, {16'd0, tbl[i].cnt});
      check($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
    end

    // Asynchronous reset landing between edges in the middle of an LW wait.
    run = 1'b1; instruction = 8'h40; mem_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (state_out == 3'd4) hit = 1'b1;
    end
    check("lw_reach_mem", {31'd0, hit}, 32'd1);
    tick();
    check("lw_mem_memread", {31'd0, memread}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_state", {29'd0, state_out}, 32'd0);
    check("async_memread", {31'd0, memread}, 32'd0);
    check("async_count", {16'd0, instr_count}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    check("async_ctrl", {21'd0, ctrl}, 32'd0);

    // Single-step: one J per press, a held button does not repeat.
    do_reset();
    instruction = 8'hC0; step = 1'b1;
    begin
      logic [2:0] exp_st[10] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      for (int i = 0; i < 10; i++) begin
        tick();
        check($sformatf("step_state%0d", i), {29'd0, state_out}, {29'd0, exp_st[i]});
        if (i == 3) check("step_done_ctrl", {21'd0, ctrl}, {21'd0, C_PCW | C_PCS | C_BR});
      end
    end
    step = 1'b0;
    tick();
    check("step_count1", {16'd0, instr_count}, 32'd1);
    step = 1'b1;
    tick();
    check("step2_fetch", {29'd0, state_out}, 32'd1);
    step = 1'b0;
    repeat (4) tick();
    check("step2_idle", {29'd0, state_out}, 32'd0);
    check("step_count2", {16'd0, instr_count}, 32'd2);

    // SW with no mem_ready: exactly MEM_TIMEOUT memwrite cycles, then locked in ERROR.
    do_reset();
    run = 1'b1; instruction = 8'h80;
    mw_cycles = 0; hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      if (memwrite) mw_cycles++;
      if (state_out == 3'd7) hit = 1'b1;
    end
    check("sw_reach_error", {31'd0, hit}, 32'd1);
    check("sw_memwrite_cycles", mw_cycles, 32'd15);
    check("sw_err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step = i[0]; run = i[1]; mem_ready = i[2];
      tick();
      check("err_hold_state", {29'd0, state_out}, 32'd7);
      check("err_hold_ctrl", {21'd0, ctrl}, 32'd0);
      check("err_hold_err", {31'd0, err}, 32'd1);
    end

    // Instruction changes to SW after DECODE: the ADD still completes via WB.
    do_reset();
    run = 1'b1; instruction = 8'h00;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (state_out == 3'd3) hit = 1'b1;
    end
    check("chg_reach_exec", {31'd0, hit}, 32'd1);
    instruction = 8'h80;
    saw_mw = 1'b0; saw_wb = 1'b0; hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (memwrite) saw_mw = 1'b1;
      if (state_out == 3'd5 && regwrite && regdst) saw_wb = 1'b1;
      if (state_out == 3'd6) hit = 1'b1;
    end
    check("chg_reach_done", {31'd0, hit}, 32'd1);
    check("chg_no_memwrite", {31'd0, saw_mw}, 32'd0);
    check("chg_add_wb", {31'd0, saw_wb}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
